mprj_io_cfg_xmit: RTL and testbench
===================================

// Module: mprj_io_cfg_xmit
// PURPOSE
//  Transmit end of the user-project pad configuration chain. Holds one config word per
//  mprj_io pad (dm, oeb, inp_dis, vtrip/slow/holdover/ib_mode, analog_*, mgmt_en).
//  On request, shifts all words serially to the per-pad control blocks, then strobes load
//  so the pad controls change simultaneously. Sits in housekeeping, between the wishbone
//  register file and the chip_io pad ring.
// PARAMETERS
//  NUM_PADS  37       number of mprj_io pads in the chain (= MPRJ_IO_PADS)
//  CFG_BITS  13       bits per pad word
//  CLK_DIV   4        system clocks per serial_clock half-period (>=1)
// PORTS
//  clock            in   1        system clock
//  reset            in   1        asynchronous, active-high reset
//  cfg_we           in   1        write cfg_wdata to word cfg_addr
//  cfg_addr         in   6        pad index
//  cfg_wdata        in   CFG_BITS word to write
//  cfg_rdata        out  CFG_BITS combinational read of word cfg_addr
//  xfer_start       in   1        one-cycle request to send the whole array
//  busy             out  1        transfer in progress
//  done             out  1        one-cycle pulse when a transfer completes
//  serial_clock     out  1        chain shift clock
//  serial_data_out  out  1        chain data; changes only while serial_clock is low
//  serial_load      out  1        chain load strobe
//  serial_resetn    out  1        chain reset, active-low
// BEHAVIOUR
//  Word layout: [12:10] dm, [9] analog_pol, [8] analog_sel, [7] analog_en, [6] ib_mode_sel,
//   [5] vtrip_sel, [4] slow_sel, [3] holdover, [2] inp_dis, [1] oeb, [0] mgmt_en.
//  Reset: every word = 13'h0403 (dm=001, oeb=1, mgmt_en=1). busy=0, done=0, serial_clock=0,
//   serial_data_out=0, serial_load=0, serial_resetn=0. serial_resetn rises on the first
//   clock edge after reset deasserts.
//  Writes: cfg_we applies at the clock edge. Ignored when busy=1 or cfg_addr>=NUM_PADS.
//   cfg_rdata=0 for out-of-range addresses.
//  N = NUM_PADS*CFG_BITS. xfer_start while busy=1 is ignored.
//  FSM IDLE -> SHIFT_LO -> SHIFT_HI -> (SHIFT_LO | LOAD_HI) -> LOAD_LO -> IDLE.
//   IDLE: when xfer_start=1, the array is copied into an N-bit shift register: pad
//    NUM_PADS-1 at the MSB end, each word MSB first. busy=1 from the next cycle.
//   SHIFT_LO: serial_clock=0 for CLK_DIV cycles. serial_data_out=current bit.
//   SHIFT_HI: serial_clock=1 for CLK_DIV cycles. Afterward the bit counter increments. After
//    bit N-1, go to LOAD_HI; otherwise shift by 1 and return to SHIFT_LO.
//   LOAD_HI: serial_load=1 for CLK_DIV cycles. LOAD_LO: serial_load=0 for CLK_DIV cycles,
//    then done=1 for one cycle, busy=0, and the state returns to IDLE.
//  busy stays high for exactly (N+1)*2*CLK_DIV cycles; default = 3856.
//  serial_load and serial_clock are never high in the same cycle.
//  Array writes made during a transfer are dropped; the snapshot is unaffected.
//  Reset mid-transfer: every output returns to its reset value at once. serial_resetn=0
//   clears the partly shifted chain.
// CONFIGURATION
//  MPRJ_IO_CFG_READBACK_EN defined:
//   - Adds input serial_data_in (end of the chain) and input cfg_rsel.
//   - serial_data_in is sampled on the cycle serial_clock goes 0->1 and shifted into the
//     shift-register LSB.
//   - At done, the captured N bits are latched into a readback array. When cfg_rsel=1,
//     cfg_rdata returns the readback word. Readback array reset = 0.
//  Undefined: neither port exists, 0 shifts into the LSB, and cfg_rdata always reads the
//   config array.
// STRUCTURE
//  Shared package mprj_cfg_pkg holds:
//   - CFG_BITS and the field offset/width constants above
//   - the reset word 13'h0403
//   - the FSM state encoding
//  One sub-module, mprj_cfg_sclk_div: CLK_DIV phase counter with a phase-end tick.
//  The FSM, bit counter, shift register and array are in this module.
// TESTING
//  - Reset, then read all pads -> cfg_rdata=13'h0403 everywhere; serial_resetn 0 then 1.
//  - NUM_PADS=2, CLK_DIV=2, words {13'h1ABC,13'h0155}; pulse xfer_start -> 26 serial_clock
//    rising edges. Data at the rising edges = 1ABC MSB-first, then 0155 MSB-first. One
//    serial_load pulse 2 cycles wide. busy high exactly 108 cycles. done pulses once.
//  - Default parameters: xfer_start held for 3 cycles, then a cfg_we to pad 5 mid-transfer
//    -> one transfer of 3856 cycles; pad 5 word unchanged after done.
//  - Write cfg_addr=40 with 13'h1FFF -> no array change; cfg_rdata=0 at addr 40.
//  - Assert reset at bit 100 of a transfer -> busy/serial_clock/serial_load drop in the
//    same cycle; serial_resetn=0; no done pulse.
//  - With MPRJ_IO_CFG_READBACK_EN: serial_data_out looped through an N-bit delay line into
//    serial_data_in. Send image A, then image B -> after the 2nd done, cfg_rsel=1 reads
//    image A.

Source files
------------

// File: rtl/mprj_cfg_pkg.sv
// mprj_cfg_pkg: pad config word layout, reset word and transmitter state encoding
package mprj_cfg_pkg;
  localparam int CFG_BITS = 13;
  localparam int DM_LSB          = 10;
  localparam int DM_W            = 3;
  localparam int ANALOG_POL_BIT  = 9;
  localparam int ANALOG_SEL_BIT  = 8;
  localparam int ANALOG_EN_BIT   = 7;
  localparam int IB_MODE_SEL_BIT = 6;
  localparam int VTRIP_SEL_BIT   = 5;
  localparam int SLOW_SEL_BIT    = 4;
  localparam int HOLDOVER_BIT    = 3;
  localparam int INP_DIS_BIT     = 2;
  localparam int OEB_BIT         = 1;
  localparam int MGMT_EN_BIT     = 0;
  localparam logic [CFG_BITS-1:0] CFG_RESET_WORD = 13'h0403;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LOAD_HI,
    ST_LOAD_LO
  } xmit_state_t;
endpackage

// File: rtl/mprj_cfg_sclk_div.sv
// mprj_cfg_sclk_div: counts CLK_DIV clocks per serial phase and ticks on the last one
module mprj_cfg_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(CLK_DIV + 1);
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(CLK_DIV - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (!en || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/mprj_io_cfg_xmit.sv
// mprj_io_cfg_xmit: pad config array and serial chain transmitter; MPRJ_IO_CFG_READBACK_EN adds chain readback
module mprj_io_cfg_xmit
  import mprj_cfg_pkg::*;
#(
  parameter int NUM_PADS = 37,
  parameter int CLK_DIV  = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [5:0]          cfg_addr,
  input  logic [CFG_BITS-1:0] cfg_wdata,
  output logic [CFG_BITS-1:0] cfg_rdata,
  input  logic                xfer_start,
  output logic                busy,
  output logic                done,
  output logic                serial_clock,
  output logic                serial_data_out,
  output logic                serial_load,
  output logic                serial_resetn
`ifdef MPRJ_IO_CFG_READBACK_EN
  ,
  input  logic                serial_data_in,
  input  logic                cfg_rsel
`endif
);
  localparam int N  = NUM_PADS * CFG_BITS;
  localparam int AW = NUM_PADS > 1 ? $clog2(NUM_PADS) : 1;
  localparam int BW = $clog2(N + 1);
  xmit_state_t state;
  logic [CFG_BITS-1:0] cfg [NUM_PADS];
  logic [N-1:0] sr, snap;
  logic [BW-1:0] bit_cnt;
  logic [AW-1:0] idx;
  logic in_range, tick, shift_in, last_bit;
  assign idx = cfg_addr[AW-1:0];
  assign in_range = 32'(cfg_addr) < NUM_PADS;
  assign last_bit = bit_cnt == BW'(N - 1);
  assign serial_data_out = sr[N-1];
  mprj_cfg_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clock (clock),
    .reset (reset),
    .en    (state != ST_IDLE),
    .tick  (tick)
  );
  always_comb begin
    snap = '0;
    for (int i = 0; i < NUM_PADS; i++) snap[i*CFG_BITS +: CFG_BITS] = cfg[i];
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) for (int i = 0; i < NUM_PADS; i++) cfg[i] <= CFG_RESET_WORD;
    else if (cfg_we && !busy && in_range) cfg[idx] <= cfg_wdata;
  // Every phase lasts one divider period; the final shift drains the captured chain bit.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state         <= ST_IDLE;
      sr            <= '0;
      bit_cnt       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      serial_clock  <= 1'b0;
      serial_load   <= 1'b0;
      serial_resetn <= 1'b0;
    end else begin
      serial_resetn <= 1'b1;
      done          <= 1'b0;
      case (state)
        ST_IDLE:
          if (xfer_start) begin
            sr      <= snap;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= ST_SHIFT_LO;
          end
        ST_SHIFT_LO:
          if (tick) begin
            serial_clock <= 1'b1;
            state        <= ST_SHIFT_HI;
          end
        ST_SHIFT_HI:
          if (tick) begin
            serial_clock <= 1'b0;
            sr           <= {sr[N-2:0], shift_in};
            bit_cnt      <= bit_cnt + 1'b1;
            serial_load  <= last_bit;
            state        <= last_bit ? ST_LOAD_HI : ST_SHIFT_LO;
          end
        ST_LOAD_HI:
          if (tick) begin
            serial_load <= 1'b0;
            state       <= ST_LOAD_LO;
          end
        ST_LOAD_LO:
          if (tick) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        default: state <= ST_IDLE;
      endcase
    end
`ifdef MPRJ_IO_CFG_READBACK_EN
  logic cap;
  logic [CFG_BITS-1:0] rb [NUM_PADS];
  assign shift_in = cap;
  assign cfg_rdata = !in_range ? '0 : cfg_rsel ? rb[idx] : cfg[idx];
  always_ff @(posedge clock or posedge reset)
    if (reset) cap <= 1'b0;
    else if (state == ST_SHIFT_LO && tick) cap <= serial_data_in;
  always_ff @(posedge clock or posedge reset)
    if (reset) for (int i = 0; i < NUM_PADS; i++) rb[i] <= '0;
    else if (state == ST_LOAD_LO && tick)
      for (int i = 0; i < NUM_PADS; i++) rb[i] <= sr[i*CFG_BITS +: CFG_BITS];
`else
  assign shift_in = 1'b0;
  assign cfg_rdata = in_range ? cfg[idx] : '0;
`endif
endmodule

// File: tb/tb_mprj_io_cfg_xmit.sv
// tb_mprj_io_cfg_xmit: checks a 2-pad/CLK_DIV=2 instance and a default instance against a serial-stream model
module tb_mprj_io_cfg_xmit;
  import mprj_cfg_pkg::*;
  localparam int SP = 2, SD = 2, DP = 37, DD = 4;
  localparam int SN = SP * CFG_BITS, DN = DP * CFG_BITS;
  logic clk = 0;
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  logic s_rst = 1, s_we = 0, s_start = 0;
  logic [5:0] s_addr = '0;
  logic [CFG_BITS-1:0] s_wdata = '0, s_rdata;
  logic s_busy, s_done, s_sclk, s_sdo, s_load, s_rstn;
  logic d_rst = 1, d_we = 0, d_start = 0;
  logic [5:0] d_addr = '0;
  logic [CFG_BITS-1:0] d_wdata = '0, d_rdata;
  logic d_busy, d_done, d_sclk, d_sdo, d_load, d_rstn;
`ifdef MPRJ_IO_CFG_READBACK_EN
  logic s_sdi, s_rsel = 0, d_rsel = 0;
  logic [SN-1:0] dl = '0;
  always @(posedge s_sclk) dl <= {dl[SN-2:0], s_sdo};
  assign s_sdi = dl[SN-1];
`endif
  mprj_io_cfg_xmit #(.NUM_PADS(SP), .CLK_DIV(SD)) dut_s (
    .clock(clk), .reset(s_rst), .cfg_we(s_we), .cfg_addr(s_addr), .cfg_wdata(s_wdata),
    .cfg_rdata(s_rdata), .xfer_start(s_start), .busy(s_busy), .done(s_done),
    .serial_clock(s_sclk), .serial_data_out(s_sdo), .serial_load(s_load), .serial_resetn(s_rstn)
`ifdef MPRJ_IO_CFG_READBACK_EN
    , .serial_data_in(s_sdi), .cfg_rsel(s_rsel)
`endif
  );
  mprj_io_cfg_xmit dut_d (
    .clock(clk), .reset(d_rst), .cfg_we(d_we), .cfg_addr(d_addr), .cfg_wdata(d_wdata),
    .cfg_rdata(d_rdata), .xfer_start(d_start), .busy(d_busy), .done(d_done),
    .serial_clock(d_sclk), .serial_data_out(d_sdo), .serial_load(d_load), .serial_resetn(d_rstn)
`ifdef MPRJ_IO_CFG_READBACK_EN
    , .serial_data_in(1'b0), .cfg_rsel(d_rsel)
`endif
  );
  logic s_bits[$], d_bits[$];
  logic s_sclk_q = 0, s_load_q = 0, s_sdo_q = 0, d_sclk_q = 0;
  int s_busy_cyc, s_done_n, s_load_cyc, s_load_pulses, s_overlap, s_dchg;
  int d_busy_cyc, d_done_n, d_rise;
  always @(negedge clk) begin
    if (s_sclk && !s_sclk_q) s_bits.push_back(s_sdo);
    if (s_busy) s_busy_cyc++;
    if (s_done) s_done_n++;
    if (s_load) s_load_cyc++;
    if (s_load && !s_load_q) s_load_pulses++;
    if (s_load && s_sclk) s_overlap++;
    if (s_sclk && s_sclk_q && s_sdo !== s_sdo_q) s_dchg++;
    s_sclk_q = s_sclk;
    s_load_q = s_load;
    s_sdo_q  = s_sdo;
    if (d_sclk && !d_sclk_q) begin
      d_bits.push_back(d_sdo);
      d_rise++;
    end
    if (d_busy) d_busy_cyc++;
    if (d_done) d_done_n++;
    d_sclk_q = d_sclk;
  end
  logic [CFG_BITS-1:0] s_model [SP];
  logic [CFG_BITS-1:0] d_model [DP];
  typedef struct {
    logic                we;
    logic [5:0]          addr;
    logic [CFG_BITS-1:0] wdata;
    logic [CFG_BITS-1:0] exp;
  } vec_t;
  vec_t vt[12];
  task automatic s_write(input logic [5:0] a, input logic [CFG_BITS-1:0] w);
    s_addr = a; s_wdata = w; s_we = 1;
    @(posedge clk); #1 s_we = 0;
    if (a < SP) s_model[a] = w;
  endtask
  task automatic s_xfer();
    s_bits.delete();
    s_busy_cyc = 0; s_done_n = 0; s_load_cyc = 0; s_load_pulses = 0; s_overlap = 0; s_dchg = 0;
    s_start = 1;
    @(posedge clk); #1 s_start = 0;
    for (int i = 0; i < 400 && !s_done; i++) @(negedge clk);
    check("s_done_seen", s_done, 1);
    repeat (3) @(negedge clk);
    #1;
  endtask
  task automatic s_check_xfer(string nm);
    int bad = 0;
    check({nm, "_bits"}, s_bits.size(), SN);
    for (int k = 0; k < SN; k++)
      if (k >= s_bits.size() || s_bits[k] !== s_model[SP-1-k/CFG_BITS][CFG_BITS-1-k%CFG_BITS]) bad++;
    check({nm, "_stream_errs"}, bad, 0);
    check({nm, "_busy_cycles"}, s_busy_cyc, (SN + 1) * 2 * SD);
    check({nm, "_done_pulses"}, s_done_n, 1);
    check({nm, "_load_pulses"}, s_load_pulses, 1);
    check({nm, "_load_cycles"}, s_load_cyc, SD);
    check({nm, "_load_clk_overlap"}, s_overlap, 0);
    check({nm, "_data_chg_hi"}, s_dchg, 0);
  endtask
  initial begin
    logic [CFG_BITS-1:0] img_a [SP];
    logic [CFG_BITS-1:0] w;
    int bad;
    for (int p = 0; p < SP; p++) s_model[p] = CFG_RESET_WORD;
    for (int p = 0; p < DP; p++) d_model[p] = CFG_RESET_WORD;
    vt[0]  = '{1'b0, 6'd0,  13'h0000, 13'h0403};
    vt[1]  = '{1'b1, 6'd5,  13'h1234, 13'h1234};
    vt[2]  = '{1'b1, 6'd40, 13'h1FFF, 13'h0000};
    vt[3]  = '{1'b0, 6'd3,  13'h0000, 13'h0403};
    vt[4]  = '{1'b1, 6'd36, 13'h0AAA, 13'h0AAA};
    vt[5]  = '{1'b1, 6'd37, 13'h1555, 13'h0000};
    vt[6]  = '{1'b1, 6'd63, 13'h1FFF, 13'h0000};
    vt[7]  = '{1'b0, 6'd36, 13'h0000, 13'h0AAA};
    vt[8]  = '{1'b0, 6'd5,  13'h0000, 13'h1234};
    vt[9]  = '{1'b1, 6'd0,  13'h1FFF, 13'h1FFF};
    vt[10] = '{1'b1, 6'd12, 13'h0000, 13'h0000};
    vt[11] = '{1'b0, 6'd1,  13'h0000, 13'h0403};
    repeat (3) @(posedge clk);
    #1;
    check("rst_resetn", d_rstn, 0);
    check("rst_busy", d_busy, 0);
    check("rst_done", d_done, 0);
    check("rst_sclk", d_sclk, 0);
    check("rst_sdo", d_sdo, 0);
    check("rst_load", d_load, 0);
    check("rst_s_outs", {s_busy, s_done, s_sclk, s_sdo, s_load, s_rstn}, 0);
    @(negedge clk);
    s_rst = 0; d_rst = 0;
    #1 check("resetn_before_edge", d_rstn, 0);
    @(posedge clk); #1;
    check("resetn_after_edge", d_rstn, 1);
    check("s_resetn_after_edge", s_rstn, 1);
    for (int p = 0; p < DP; p++) begin
      d_addr = 6'(p);
      #1 check($sformatf("rst_word_pad%0d", p), d_rdata, 13'h0403);
    end
`ifdef MPRJ_IO_CFG_READBACK_EN
    s_rsel = 1; s_addr = 0;
    #1 check("rb_reset_word", s_rdata, 0);
    s_rsel = 0;
`endif
    s_write(6'd1, 13'h1ABC);
    s_write(6'd0, 13'h0155);
    s_xfer();
    s_check_xfer("two_pad");
    for (int it = 0; it < 4; it++) begin
      for (int p = 0; p < SP; p++) s_write(6'(p), 13'($urandom));
      s_write(6'($urandom_range(SP, 63)), 13'($urandom));
      for (int p = 0; p < SP; p++) begin
        s_addr = 6'(p);
        #1 check($sformatf("rand%0d_rd%0d", it, p), s_rdata, s_model[p]);
      end
      s_addr = 6'($urandom_range(SP, 63));
      #1 check($sformatf("rand%0d_rd_oob", it), s_rdata, 0);
      s_xfer();
      s_check_xfer($sformatf("rand%0d", it));
    end
`ifdef MPRJ_IO_CFG_READBACK_EN
    for (int p = 0; p < SP; p++) begin
      w = 13'($urandom);
      img_a[p] = w;
      s_write(6'(p), w);
    end
    s_xfer();
    for (int p = 0; p < SP; p++) s_write(6'(p), 13'($urandom));
    s_xfer();
    s_rsel = 1;
    for (int p = 0; p < SP; p++) begin
      s_addr = 6'(p);
      #1 check($sformatf("rb_img_a_pad%0d", p), s_rdata, img_a[p]);
    end
    s_rsel = 0;
    for (int p = 0; p < SP; p++) begin
      s_addr = 6'(p);
      #1 check($sformatf("rb_cfg_pad%0d", p), s_rdata, s_model[p]);
    end
`endif
    foreach (vt[i]) begin
      d_addr = vt[i].addr; d_wdata = vt[i].wdata; d_we = vt[i].we;
      @(posedge clk); #1 d_we = 0;
      if (vt[i].we && vt[i].addr < DP) d_model[vt[i].addr] = vt[i].wdata;
      check($sformatf("vec%0d_addr%0d", i, vt[i].addr), d_rdata, vt[i].exp);
    end
    d_bits.delete(); d_busy_cyc = 0; d_done_n = 0; d_rise = 0;
    d_start = 1;
    repeat (3) @(posedge clk);
    #1 d_start = 0;
    repeat (500) @(posedge clk);
    #1 d_addr = 6'd5; d_wdata = 13'h0F0F; d_we = 1;
    @(posedge clk); #1 d_we = 0;
    for (int i = 0; i < 5000 && !d_done; i++) @(negedge clk);
    check("dflt_done_seen", d_done, 1);
    repeat (20) @(negedge clk);
    #1;
    check("dflt_busy_cycles", d_busy_cyc, 3856);
    check("dflt_done_pulses", d_done_n, 1);
    check("dflt_idle_after", d_busy, 0);
    check("dflt_bits", d_bits.size(), DN);
    bad = 0;
    for (int k = 0; k < DN; k++)
      if (k >= d_bits.size() || d_bits[k] !== d_model[DP-1-k/CFG_BITS][CFG_BITS-1-k%CFG_BITS]) bad++;
    check("dflt_stream_errs", bad, 0);
    d_addr = 6'd5;
    #1 check("dflt_pad5_kept", d_rdata, 13'h1234);
    d_busy_cyc = 0; d_done_n = 0; d_rise = 0;
    @(posedge clk); #1 d_start = 1;
    @(posedge clk); #1 d_start = 0;
    for (int i = 0; i < 3000 && d_rise < 100; i++) @(negedge clk);
    check("mid_rst_reached_bit100", d_rise >= 100, 1);
    check("mid_rst_sclk_high", d_sclk, 1);
    d_rst = 1;
    #1;
    check("mid_rst_busy", d_busy, 0);
    check("mid_rst_sclk", d_sclk, 0);
    check("mid_rst_load", d_load, 0);
    check("mid_rst_resetn", d_rstn, 0);
    check("mid_rst_sdo", d_sdo, 0);
    repeat (5) @(posedge clk);
    #1 d_rst = 0;
    repeat (50) @(negedge clk);
    #1;
    check("mid_rst_no_done", d_done_n, 0);
    check("mid_rst_idle", d_busy, 0);
    check("mid_rst_resetn_up", d_rstn, 1);
    check("mid_rst_pad5_word", d_rdata, 13'h0403);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
